// File: rtl/i2s_receiver_rx.sv
// I2S (Philips format) slave receiver: oversamples bclk/lrclk/sdata in the system clock
// domain, recovers the left/right words and publishes one stereo pair per frame.
module i2s_receiver_rx #(
    parameter int I2S_RECEIVER_DATA_WIDTH  = 24,
    parameter int I2S_RECEIVER_SYNC_STAGES = 2
) (
    input  logic                               i2s_receiver_clk,
    input  logic                               i2s_receiver_rst,
    input  logic                               i2s_receiver_bclk,
    input  logic                               i2s_receiver_lrclk,
    input  logic                               i2s_receiver_sdata,
    output logic [I2S_RECEIVER_DATA_WIDTH-1:0] left_data,
    output logic [I2S_RECEIVER_DATA_WIDTH-1:0] right_data,
    output logic                               data_valid,
    output logic                               frame_err
);

    localparam int W  = I2S_RECEIVER_DATA_WIDTH;
    localparam int SS = I2S_RECEIVER_SYNC_STAGES;
    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

    typedef enum logic [1:0] {
        HUNT,
        SHIFT,
        IDLE_SLOT
    } state_t;

    logic [SS-1:0] bclk_sync;
    logic [SS-1:0] lrclk_sync;
    logic [SS-1:0] sdata_sync;

    logic          bclk_prev;
    logic          rise_p0;
    logic          lrclk_p0;
    logic          sdata_p0;

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic          ch_q;
    logic [W-1:0]  sreg_q;
    logic [W-1:0]  sreg_next;
    logic          lr_prev_q;
    logic          lr_seen_q;
    logic          left_pend_q;

    logic          boundary;
    logic          restart;
    logic          shift_en;
    logic          word_done;
    logic          slot_err;

    // Synchroniser stage: every pin gets the same depth so bits stay aligned with bclk.
    always_ff @(posedge i2s_receiver_clk) begin
        if (i2s_receiver_rst) begin
            bclk_sync  <= '0;
            lrclk_sync <= '0;
            sdata_sync <= '0;
        end else begin
            bclk_sync  <= {bclk_sync[SS-2:0], i2s_receiver_bclk};
            lrclk_sync <= {lrclk_sync[SS-2:0], i2s_receiver_lrclk};
            sdata_sync <= {sdata_sync[SS-2:0], i2s_receiver_sdata};
        end
    end

    // Stage p0: registered bclk rise strobe with the lrclk/sdata values seen at that rise.
    always_ff @(posedge i2s_receiver_clk) begin
        if (i2s_receiver_rst) begin
            bclk_prev <= 1'b0;
            rise_p0   <= 1'b0;
        end else begin
            bclk_prev <= bclk_sync[SS-1];
            rise_p0   <= bclk_sync[SS-1] & ~bclk_prev;
        end
    end

    always_ff @(posedge i2s_receiver_clk) begin
        lrclk_p0 <= lrclk_sync[SS-1];
        sdata_p0 <= sdata_sync[SS-1];
    end

    // The first rise after reset only records lrclk, so a slot already in flight is never framed.
    assign boundary  = rise_p0 && lr_seen_q && (lrclk_p0 != lr_prev_q);
    assign sreg_next = {sreg_q[W-2:0], sdata_p0};

    always_comb begin
        state_d   = state_q;
        restart   = 1'b0;
        shift_en  = 1'b0;
        word_done = 1'b0;
        slot_err  = 1'b0;
        if (rise_p0) begin
            case (state_q)
                HUNT: begin
                    if (boundary) begin
                        state_d = SHIFT;
                        restart = 1'b1;
                    end
                end
                SHIFT: begin
                    // A boundary before the W-th bit (including on it) means a short slot.
                    if (boundary) begin
                        slot_err = 1'b1;
                        restart  = 1'b1;
                    end else begin
                        shift_en = 1'b1;
                        if (cnt_q == LAST_BIT) begin
                            word_done = 1'b1;
                            state_d   = IDLE_SLOT;
                        end
                    end
                end
                IDLE_SLOT: begin
                    if (boundary) begin
                        state_d = SHIFT;
                        restart = 1'b1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // Stage p1: FSM state, word latching and the valid/error pulses.
    always_ff @(posedge i2s_receiver_clk) begin
        if (i2s_receiver_rst) begin
            state_q     <= HUNT;
            cnt_q       <= '0;
            ch_q        <= 1'b0;
            lr_prev_q   <= 1'b0;
            lr_seen_q   <= 1'b0;
            left_pend_q <= 1'b0;
            left_data   <= '0;
            right_data  <= '0;
            data_valid  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_valid <= word_done && ch_q && left_pend_q;
            frame_err  <= slot_err;
            if (rise_p0) begin
                lr_prev_q <= lrclk_p0;
                lr_seen_q <= 1'b1;
            end
            if (restart) begin
                cnt_q <= '0;
                ch_q  <= lrclk_p0;
            end else if (shift_en) begin
                cnt_q <= cnt_q + CW'(1);
            end
            if (word_done) begin
                if (ch_q) begin
                    right_data <= sreg_next;
                end else begin
                    left_data <= sreg_next;
                end
            end
            if (slot_err) begin
                left_pend_q <= 1'b0;
            end else if (word_done) begin
                left_pend_q <= ~ch_q;
            end
        end
    end

    always_ff @(posedge i2s_receiver_clk) begin
        if (shift_en) begin
            sreg_q <= sreg_next;
        end
    end

endmodule

// File: tb/tb_i2s_receiver_rx.sv
// Directed bench for i2s_receiver_rx: a bit-level I2S master model drives slots, a
// scoreboard of hand-chosen stereo pairs is checked on every data_valid pulse.
module tb_i2s_receiver_rx;

    localparam int W  = 24;
    localparam int SS = 2;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         bclk  = 1'b0;
    logic         lrclk = 1'b0;
    logic         sdata = 1'b0;
    logic [W-1:0] left_data;
    logic [W-1:0] right_data;
    logic         data_valid;
    logic         frame_err;

    i2s_receiver_rx #(
        .I2S_RECEIVER_DATA_WIDTH (W),
        .I2S_RECEIVER_SYNC_STAGES(SS)
    ) dut (
        .i2s_receiver_clk  (clk),
        .i2s_receiver_rst  (rst),
        .i2s_receiver_bclk (bclk),
        .i2s_receiver_lrclk(lrclk),
        .i2s_receiver_sdata(sdata),
        .left_data         (left_data),
        .right_data        (right_data),
        .data_valid        (data_valid),
        .frame_err         (frame_err)
    );

    always #5 clk = ~clk;

    int unsigned  cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int           n_checks = 0;
    int           n_fail   = 0;
    int           n_valid  = 0;
    int           n_err    = 0;
    int           half     = 4;
    logic         prev_lsb = 1'b0;
    int unsigned  rbit_cyc = 0;
    logic [2*W-1:0] expq[$];
    logic [2*W-1:0] exp_pair;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One bclk period: launch on the falling edge, rise half a period later.
    task automatic bit_period(input logic lr, input logic sd, input bit mark);
        bclk  = 1'b0;
        lrclk = lr;
        sdata = sd;
        repeat (half) @(negedge clk);
        bclk = 1'b1;
        if (mark) rbit_cyc = cyc;
        repeat (half) @(negedge clk);
    endtask

    // Slot of n bclk periods; period 0 carries the previous slot's LSB (the 1-bit delay).
    task automatic send_slot(input logic ch, input logic [W-1:0] word, input int n, input int rst_at);
        for (int i = 0; i < n; i++) begin
            logic sd;
            if (i == 0) sd = prev_lsb;
            else if (i <= W) sd = word[W-i];
            else sd = 1'b0;
            if (i == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("rst_left_data", 64'(left_data), 64'd0);
                check("rst_right_data", 64'(right_data), 64'd0);
                check("rst_data_valid", 64'(data_valid), 64'd0);
                check("rst_frame_err", 64'(frame_err), 64'd0);
            end
            bit_period(ch, sd, (ch == 1'b1) && (i == W));
        end
        if (n > W) prev_lsb = word[0];
    endtask

    task automatic frame(input logic [W-1:0] l, input logic [W-1:0] r, input int n, input bit exp_valid);
        if (exp_valid) expq.push_back({l, r});
        send_slot(1'b0, l, n, -1);
        send_slot(1'b1, r, n, -1);
    endtask

    task automatic settle();
        repeat (16) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (data_valid) begin
            n_valid++;
            if (expq.size() == 0) begin
                check("unexpected_valid", 64'(data_valid), 64'd0);
            end else begin
                exp_pair = expq.pop_front();
                check("left_data", 64'(left_data), 64'(exp_pair[2*W-1:W]));
                check("right_data", 64'(right_data), 64'(exp_pair[W-1:0]));
            end
            check("valid_latency", 64'(cyc - rbit_cyc), 64'(SS + 2));
        end
        if (frame_err) n_err++;
        if (data_valid || frame_err) check("valid_err_excl", 64'(data_valid & frame_err), 64'd0);
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int v0;
        int e0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        check("reset_left_data", 64'(left_data), 64'd0);
        check("reset_right_data", 64'(right_data), 64'd0);
        check("reset_data_valid", 64'(data_valid), 64'd0);
        check("reset_frame_err", 64'(frame_err), 64'd0);

        // 8x bclk, 32-bit slots: first frame is dropped, three pairs follow.
        v0 = n_valid; e0 = n_err;
        frame(24'hA5A5A5, 24'h5A5A5A, 33, 1'b0);
        repeat (3) frame(24'hA5A5A5, 24'h5A5A5A, 33, 1'b1);
        settle();
        check("t1_valid_count", 64'(n_valid - v0), 64'd3);
        check("t1_err_count", 64'(n_err - e0), 64'd0);

        // Tight slots: delay bit plus exactly W data bits.
        v0 = n_valid; e0 = n_err;
        frame(24'h123456, 24'hFEDCBA, W + 1, 1'b1);
        frame(24'h800001, 24'h7FFFFE, W + 1, 1'b1);
        frame(24'hFFFFFF, 24'h000000, W + 1, 1'b1);
        settle();
        check("t2_valid_count", 64'(n_valid - v0), 64'd3);
        check("t2_err_count", 64'(n_err - e0), 64'd0);

        // lrclk toggles after 16 left bits: one error, no pair, next frame recovers.
        v0 = n_valid; e0 = n_err;
        send_slot(1'b0, 24'hC3C3C3, 17, -1);
        send_slot(1'b1, 24'h3C3C3C, 33, -1);
        frame(24'h0F0F0F, 24'hF0F0F0, 33, 1'b1);
        settle();
        check("t3_valid_count", 64'(n_valid - v0), 64'd1);
        check("t3_err_count", 64'(n_err - e0), 64'd1);

        // Boundary lands on the W-th left bit: still a short slot.
        v0 = n_valid; e0 = n_err;
        send_slot(1'b0, 24'h111111, W, -1);
        send_slot(1'b1, 24'h222222, 33, -1);
        frame(24'h333333, 24'h444444, 33, 1'b1);
        settle();
        check("t3b_valid_count", 64'(n_valid - v0), 64'd1);
        check("t3b_err_count", 64'(n_err - e0), 64'd1);

        // One-cycle reset in the middle of a right slot.
        v0 = n_valid; e0 = n_err;
        frame(24'hABCDEF, 24'h654321, 33, 1'b1);
        send_slot(1'b0, 24'h999999, 33, -1);
        send_slot(1'b1, 24'h888888, 33, 10);
        frame(24'h13579B, 24'h2468AC, 33, 1'b1);
        frame(24'hDEAD01, 24'hBEEF02, 33, 1'b1);
        settle();
        check("t4_valid_count", 64'(n_valid - v0), 64'd3);
        check("t4_err_count", 64'(n_err - e0), 64'd0);

        // Counter source: consecutive pairs, no gaps.
        v0 = n_valid; e0 = n_err;
        for (int k = 0; k < 20; k++) frame(W'(2 * k), W'(2 * k + 1), 33, 1'b1);
        settle();
        check("t5_valid_count", 64'(n_valid - v0), 64'd20);
        check("t5_err_count", 64'(n_err - e0), 64'd0);

        // Minimum 4x ratio, random data and slot lengths.
        half = 2;
        v0 = n_valid; e0 = n_err;
        for (int k = 0; k < 50; k++) begin
            frame(W'($urandom), W'($urandom), W + 1 + int'($urandom_range(0, 8)), 1'b1);
        end
        settle();
        check("t6_valid_count", 64'(n_valid - v0), 64'd50);
        check("t6_err_count", 64'(n_err - e0), 64'd0);
        check("scoreboard_empty", 64'(expq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
